// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add WORD_WIDTH x WORD_WIDTH multiplier that borrows the
// shared ALU adder once per multiplier bit. Define MUL_SIGNED_EN for two's-complement operands.
module alu_mul_sequencer #(
    parameter int         WORD_WIDTH     = 32,
    parameter logic [2:0] ALU_ADD_OPCODE = 3'd0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] multiplicand,
    input  logic [WORD_WIDTH-1:0] multiplier,
`ifdef MUL_SIGNED_EN
    input  logic                  signed_op,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] product_hi,
    output logic [WORD_WIDTH-1:0] product_lo,
    output logic                  alu_req,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    output logic                  alu_ic,
    output logic [2:0]            alu_opcode,
    input  logic [WORD_WIDTH-1:0] alu_out,
    input  logic                  alu_oc,
    output logic [1:0]            dbg_state
);

    // Handshake: start is taken only while busy=0 (IDLE); operands are captured on that edge.
    // busy stays high until the sequencer is back in IDLE; done is a single-cycle pulse and the
    // product outputs then hold until the next accepted start.

    localparam int CW = $clog2(WORD_WIDTH) + 1;
    localparam logic [CW-1:0]           CNT_LOAD = CW'(WORD_WIDTH);
    localparam logic [CW-1:0]           CNT_ONE  = CW'(1);
    localparam logic [WORD_WIDTH-1:0]   ZERO_W   = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   m_q, m_d;
    logic [WORD_WIDTH-1:0]   hi_q, hi_d;
    logic [WORD_WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   a_mag;
    logic [WORD_WIDTH-1:0]   b_mag;
    logic                    negate_pending;

`ifdef MUL_SIGNED_EN
    localparam logic [WORD_WIDTH-1:0]   ONE_W   = WORD_WIDTH'(1);
    localparam logic [2*WORD_WIDTH-1:0] ONE_2W  = (2*WORD_WIDTH)'(1);

    logic                    neg_q, neg_d;
    logic                    a_neg, b_neg;
    logic [2*WORD_WIDTH-1:0] prod_negated;

    // The most-negative value negates to itself, which read unsigned is its true magnitude.
    assign a_neg        = signed_op & multiplicand[WORD_WIDTH-1];
    assign b_neg        = signed_op & multiplier[WORD_WIDTH-1];
    assign a_mag        = a_neg ? (~multiplicand + ONE_W) : multiplicand;
    assign b_mag        = b_neg ? (~multiplier + ONE_W) : multiplier;
    assign prod_negated = ~{hi_q, lo_q} + ONE_2W;
    assign negate_pending = neg_q;
`else
    assign a_mag          = multiplicand;
    assign b_mag          = multiplier;
    assign negate_pending = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (cnt_q == CNT_ONE) state_d = S_DONE;
            S_DONE: state_d = negate_pending ? S_FIX : S_IDLE;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_q != S_IDLE);
        alu_req    = (state_q == S_RUN);
        alu_a      = (state_q == S_RUN) ? hi_q : ZERO_W;
        alu_b      = (state_q == S_RUN) ? m_q  : ZERO_W;
        alu_ic     = 1'b0;
        alu_opcode = ALU_ADD_OPCODE;
        // With a negate pending, the pulse moves to FIX so it coincides with the corrected product.
        done       = ((state_q == S_DONE) && !negate_pending) || (state_q == S_FIX);
        dbg_state  = state_q;
    end

    // Datapath next-state
    always_comb begin
        m_d   = m_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
`ifdef MUL_SIGNED_EN
        neg_d = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d   = a_mag;
                    hi_d  = ZERO_W;
                    lo_d  = b_mag;
                    cnt_d = CNT_LOAD;
`ifdef MUL_SIGNED_EN
                    neg_d = a_neg ^ b_neg;
`endif
                end
            end
            S_RUN: begin
                // Shift right by one; the ALU carry becomes the new top bit when we added.
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {alu_oc, alu_out, lo_q[WORD_WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WORD_WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
            end
            S_DONE: begin
`ifdef MUL_SIGNED_EN
                if (neg_q) begin
                    {hi_d, lo_d} = prod_negated;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
`ifdef MUL_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
`ifdef MUL_SIGNED_EN
            neg_q <= neg_d;
`endif
        end
    end

    assign product_hi = hi_q;
    assign product_lo = lo_q;

endmodule
